uart_sym_tx: RTL

Downstream stage of the H/S read-out block. It consumes the 2-bit symbol stream that block produces (`out[1:0]` qualified by `tx_en`) and packs four symbols into a byte. Bytes are buffered in a small FIFO and transmitted as 8N1 UART frames on a single serial line. The read-out block's `done_h` drives `flush`, so a trailing partial byte is sent at the end of a matrix.

---
 rtl/uart_sym_pkg.sv | 14 +
 rtl/sym_fifo.sv | 48 ++++
 rtl/uart_sym_tx.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/uart_sym_pkg.sv
// rtl/uart_sym_pkg.sv - shared types and constants for the symbol-to-UART transmitter
package uart_sym_pkg;

   localparam int SYM_W         = 2;
   localparam int SYMS_PER_BYTE = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/sym_fifo.sv
// rtl/sym_fifo.sv - synchronous FIFO with extra-MSB pointers for full/empty detection
module sym_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_do_push;
   logic             w_do_pop;

   assign empty = (r_wr_ptr == r_rd_ptr);
   assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign dout  = r_mem[r_rd_ptr[AW-1:0]];

   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/uart_sym_tx.sv
// rtl/uart_sym_tx.sv - packs 2-bit symbols into bytes and sends them as 8N1 UART frames
module uart_sym_tx
   import uart_sym_pkg::*;
#(
   parameter int CLK_DIV    = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sym_valid,
   input  logic [SYM_W-1:0] sym_in,
   input  logic             flush,
   output logic             tx,
   output logic             tx_busy,
   output logic             idle,
   output logic             ovf
);

   localparam logic [1:0]  LAST_SYM = 2'(SYMS_PER_BYTE - 1);
   localparam logic [15:0] BIT_LAST = 16'(CLK_DIV - 1);

   tx_state_e   r_state;
   tx_state_e   w_state_nxt;
   logic [1:0]  r_sym_cnt;
   logic [1:0]  w_sym_cnt_upd;
   logic [7:0]  r_pack;
   logic [7:0]  w_pack_upd;
   logic        w_push;
   logic        w_pop;
   logic        w_full;
   logic        w_empty;
   logic [7:0]  w_fifo_dout;
   logic [15:0] r_bcnt;
   logic [2:0]  r_bitn;
   logic [7:0]  r_shreg;
   logic        r_tx;
   logic        w_tx_cur;
   logic        r_ovf;
   logic        w_bit_last;

   // Unfilled symbol slots stay zero because the pack register clears on every push.
   always_comb begin
      w_pack_upd    = r_pack;
      w_sym_cnt_upd = r_sym_cnt;
      if (sym_valid) begin
         w_pack_upd[{r_sym_cnt, 1'b0} +: SYM_W] = sym_in;
         w_sym_cnt_upd = r_sym_cnt + 2'd1;
      end
      w_push = (sym_valid && (r_sym_cnt == LAST_SYM)) ||
               (flush && (w_sym_cnt_upd != 2'd0));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sym_cnt <= '0;
         r_pack    <= '0;
         r_ovf     <= 1'b0;
      end else begin
         if (w_push) begin
            r_sym_cnt <= '0;
            r_pack    <= '0;
         end else begin
            r_sym_cnt <= w_sym_cnt_upd;
            r_pack    <= w_pack_upd;
         end
         if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      end
   end

   sym_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push),
      .din   (w_pack_upd),
      .pop   (w_pop),
      .dout  (w_fifo_dout),
      .full  (w_full),
      .empty (w_empty)
   );

   assign w_bit_last = (r_bcnt == BIT_LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_tx_cur    = 1'b1;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = START;
            end
         end
         START: begin
            w_tx_cur = 1'b0;
            if (w_bit_last) w_state_nxt = DATA;
         end
         DATA: begin
            w_tx_cur = r_shreg[0];
            if (w_bit_last && (r_bitn == 3'd7)) w_state_nxt = STOP;
         end
         STOP: begin
            if (w_bit_last) begin
               if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_state_nxt = START;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // The line level is registered, so tx trails the state by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bcnt  <= '0;
         r_bitn  <= '0;
         r_shreg <= '0;
         r_tx    <= 1'b1;
      end else begin
         r_tx <= w_tx_cur;
         if (w_pop) begin
            r_shreg <= w_fifo_dout;
            r_bcnt  <= '0;
         end else if (r_state != IDLE) begin
            r_bcnt <= w_bit_last ? 16'd0 : r_bcnt + 16'd1;
            if (w_bit_last) begin
               if (r_state == START) r_bitn <= '0;
               if (r_state == DATA) begin
                  r_shreg <= {1'b0, r_shreg[7:1]};
                  r_bitn  <= r_bitn + 3'd1;
               end
            end
         end
      end
   end

   assign tx      = r_tx;
   assign tx_busy = (r_state != IDLE);
   assign idle    = (r_sym_cnt == 2'd0) && w_empty && (r_state == IDLE);
   assign ovf     = r_ovf;

endmodule
